// File: rtl/max7219_rx_if.sv
// rtl/max7219_rx_if.sv - serial pins and shadow-register outputs of the MAX7219 receive model
interface max7219_rx_if #(
  parameter int NDEV = 4
);
  logic                 din;
  logic                 cs;
  logic                 sclk;
  logic [NDEV*64-1:0]   display;
  logic [NDEV*4-1:0]    intensity;
  logic [NDEV*3-1:0]    scan_limit;
  logic [NDEV*8-1:0]    decode;
  logic [NDEV-1:0]      shutdown_n;
  logic [NDEV-1:0]      test;
  logic                 frame_valid;
  logic                 frame_error;

  // master drives the serial lines and observes the display model
  modport master (
    output din, cs, sclk,
    input  display, intensity, scan_limit, decode, shutdown_n, test,
    input  frame_valid, frame_error
  );

  // slave is the decoder itself
  modport slave (
    input  din, cs, sclk,
    output display, intensity, scan_limit, decode, shutdown_n, test,
    output frame_valid, frame_error
  );
endinterface

// File: rtl/max7219_rx.sv
// rtl/max7219_rx.sv - MAX7219 daisy-chain receive decoder and shadow register file (option: MAX7219_RX_TEST_EN)
module max7219_rx #(
  parameter int NDEV        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  max7219_rx_if.slave   bus
);

  localparam int FRAME_BITS = 16 * NDEV;
  localparam int CW         = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [SYNC_STAGES-1:0] din_sync_q, cs_sync_q, sclk_sync_q;
  logic                   cs_dly_q, sclk_dly_q;
  logic                   din_s, cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_rise;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [FRAME_BITS-1:0]  shreg_q;
  logic                   commit_ok;

  logic [NDEV*64-1:0]     rows_q, rows_d;
  logic [NDEV*4-1:0]      intensity_q, intensity_d;
  logic [NDEV*3-1:0]      scan_q, scan_d;
  logic [NDEV*8-1:0]      decode_q, decode_d;
  logic [NDEV-1:0]        shutdown_q, shutdown_d;
  logic                   frame_valid_q, frame_error_q;
  logic [NDEV*4-1:0]      unused_hi_nibbles;

  // Synchronizers reset low so a cs already low at reset release never looks like a fall
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      din_sync_q  <= '0;
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      cs_dly_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
    end else begin
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], bus.din};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_dly_q    <= cs_s;
      sclk_dly_q  <= sclk_s;
    end
  end

  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_dly_q & ~cs_s;
  assign cs_rise   = ~cs_dly_q & cs_s;
  assign sclk_rise = ~sclk_dly_q & sclk_s;

  // Frame FSM next state; a cs rise takes priority over a coincident sclk rise
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT:  if (cs_rise) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bit counter (saturating one past a full frame) and frame shift register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && cs_fall) begin
        cnt_q <= '0;
      end else if (state_q == ST_SHIFT && !cs_rise && sclk_rise) begin
        shreg_q <= {shreg_q[FRAME_BITS-2:0], din_s};
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign commit_ok = (state_q == ST_COMMIT) && (cnt_q == CNT_FULL);

`ifdef MAX7219_RX_TEST_EN
  logic [NDEV-1:0] test_q, test_d;
`endif

  // Decode every device word of a good frame into the next shadow-register image
  always_comb begin
    rows_d      = rows_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    decode_d    = decode_q;
    shutdown_d  = shutdown_q;
`ifdef MAX7219_RX_TEST_EN
    test_d      = test_q;
`endif
    if (commit_ok) begin
      for (int k = 0; k < NDEV; k++) begin
        case (shreg_q[16*k+8 +: 4])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
            rows_d[64*k + 8*(int'(shreg_q[16*k+8 +: 4]) - 1) +: 8] = shreg_q[16*k +: 8];
          4'h9: decode_d[8*k +: 8]    = shreg_q[16*k +: 8];
          4'hA: intensity_d[4*k +: 4] = shreg_q[16*k +: 4];
          4'hB: scan_d[3*k +: 3]      = shreg_q[16*k +: 3];
          4'hC: shutdown_d[k]         = shreg_q[16*k];
`ifdef MAX7219_RX_TEST_EN
          4'hF: test_d[k]             = shreg_q[16*k];
`endif
          default: ;
        endcase
      end
    end
  end

  // Shadow registers and the one-cycle commit/error pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rows_q        <= '0;
      intensity_q   <= '0;
      scan_q        <= '0;
      decode_q      <= '0;
      shutdown_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rows_q        <= rows_d;
      intensity_q   <= intensity_d;
      scan_q        <= scan_d;
      decode_q      <= decode_d;
      shutdown_q    <= shutdown_d;
      frame_valid_q <= commit_ok;
      frame_error_q <= (state_q == ST_COMMIT) && !commit_ok;
    end
  end

  // The top nibble of each word carries no meaning in the chain protocol
  always_comb begin
    unused_hi_nibbles = '0;
    for (int k = 0; k < NDEV; k++) unused_hi_nibbles[4*k +: 4] = shreg_q[16*k+12 +: 4];
  end

`ifdef MAX7219_RX_TEST_EN
  // Test register state, kept apart so stored rows survive a test period
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) test_q <= '0;
    else       test_q <= test_d;
  end

  // Display test forces a device's whole matrix on without touching its rows
  always_comb begin
    bus.display = rows_q;
    for (int k = 0; k < NDEV; k++)
      if (test_q[k]) bus.display[64*k +: 64] = '1;
  end
  assign bus.test = test_q;
`else
  assign bus.display = rows_q;
  assign bus.test    = '0;
`endif

  assign bus.intensity   = intensity_q;
  assign bus.scan_limit  = scan_q;
  assign bus.decode      = decode_q;
  assign bus.shutdown_n  = shutdown_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_max7219_rx.sv
// tb/tb_max7219_rx.sv - directed bench for max7219_rx (NDEV=4, SYNC_STAGES=2)
module tb_max7219_rx;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   fv_cnt, fe_cnt, fv_cyc, cs_cyc;

  logic [255:0] exp_disp;
  logic [15:0]  exp_int;
  logic [11:0]  exp_scan;
  logic [31:0]  exp_dec;
  logic [3:0]   exp_shdn;
  logic [3:0]   exp_test;

  max7219_rx_if #(.NDEV(4)) bus ();

  max7219_rx #(.NDEV(4), .SYNC_STAGES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.frame_valid) begin
      fv_cnt++;
      if (fv_cyc < 0) fv_cyc = cyc;
    end
    if (bus.frame_error) fe_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".display"},    bus.display,    exp_disp);
    check({tag, ".intensity"},  bus.intensity,  exp_int);
    check({tag, ".scan_limit"}, bus.scan_limit, exp_scan);
    check({tag, ".decode"},     bus.decode,     exp_dec);
    check({tag, ".shutdown_n"}, bus.shutdown_n, exp_shdn);
    check({tag, ".test"},       bus.test,       exp_test);
  endtask

  // shift n bits MSB first; gap = clk cycles from the last sclk rise to the cs rise
  task automatic send(input logic [127:0] bits, input int n, input int gap, input bit raise);
    fv_cnt = 0;
    fe_cnt = 0;
    fv_cyc = -1;
    cs_cyc = 0;
    bus.cs = 1'b0;
    cyc_wait(3);
    for (int i = n - 1; i >= 0; i--) begin
      bus.din = bits[i];
      cyc_wait(3);
      bus.sclk = 1'b1;
      if (i == 0 && raise) begin
        cyc_wait(gap);
        cs_cyc = cyc;
        bus.cs = 1'b1;
      end
      cyc_wait(3);
      bus.sclk = 1'b0;
    end
    if (raise && n == 0) begin
      cs_cyc = cyc;
      bus.cs = 1'b1;
    end
    if (raise) cyc_wait(12);
  endtask

  task automatic check_pulses(input string tag, input int fv, input int fe);
    check({tag, ".frame_valid"}, fv_cnt, fv);
    check({tag, ".frame_error"}, fe_cnt, fe);
  endtask

  initial begin
    rst = 1'b1;
    bus.din = 1'b0;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    fv_cnt = 0; fe_cnt = 0; fv_cyc = -1; cs_cyc = 0;
    exp_disp = '0; exp_int = '0; exp_scan = '0; exp_dec = '0; exp_shdn = '0; exp_test = '0;
    cyc_wait(5);
    rst = 1'b0;
    cyc_wait(5);
    check_regs("reset");

    // basic frame: device 3 gets the first word shifted
    send({64'h0, 16'h0155, 16'h02AA, 16'h0C01, 16'h0A07}, 64, 3, 1'b1);
    check_pulses("frame1", 1, 0);
    check("frame1.latency", fv_cyc - cs_cyc, 4);
    exp_disp = (256'h55 << 192) | (256'hAA << 136);
    exp_int  = 16'h0007;
    exp_shdn = 4'b0010;
    check_regs("frame1");

    // short, long and empty frames change nothing
    send({64'h0, 64'h0A0F0A0F0A0F0A0F}, 63, 3, 1'b1);
    check_pulses("short", 0, 1);
    check_regs("short");
    send(128'h3F_0A0F_0A0F_0A0F_0A0F, 70, 3, 1'b1);
    check_pulses("long", 0, 1);
    check_regs("long");
    send(128'h0, 0, 0, 1'b1);
    check_pulses("empty", 0, 1);

    // reset in the middle of a frame
    send({64'h0, 64'h0A0F0A0F0A0F0A0F}, 30, 0, 1'b0);
    rst = 1'b1;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    cyc_wait(3);
    exp_disp = '0; exp_int = '0; exp_shdn = '0;
    check_regs("midreset");
    rst = 1'b0;
    cyc_wait(3);
    send({64'h0, 16'h0A03, 16'h0B05, 16'h0901, 16'h0C01}, 64, 3, 1'b1);
    check_pulses("frame2", 1, 0);
    exp_int  = 16'h3000;
    exp_scan = 12'h140;
    exp_dec  = 32'h0000_0100;
    exp_shdn = 4'b0001;
    check_regs("frame2");

    // cs rise coincident with the 64th sclk rise drops that edge
    send({64'h0, 16'h0101, 16'h0202, 16'h0303, 16'h0404}, 64, 0, 1'b1);
    check_pulses("coincident", 0, 1);
    check_regs("coincident");
    send({64'h0, 16'h0101, 16'h0202, 16'h0303, 16'h0404}, 64, 2, 1'b1);
    check_pulses("gap2", 1, 0);
    check("gap2.latency", fv_cyc - cs_cyc, 4);
    exp_disp = (256'h01 << 192) | (256'h02 << 136) | (256'h03 << 80) | (256'h04 << 24);
    check_regs("gap2");

    // digit1 of device 0, with ignored addresses 0xD/0xE and a no-op elsewhere
    send({64'h0, 16'h0D55, 16'h0E66, 16'h0000, 16'h013C}, 64, 3, 1'b1);
    check_pulses("digit", 1, 0);
    exp_disp[63:0] = 64'h0000_0000_0400_003C;
    check_regs("digit");

    send({64'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0F01}, 64, 3, 1'b1);
    check_pulses("test_on", 1, 0);
`ifdef MAX7219_RX_TEST_EN
    exp_disp[63:0] = '1;
    exp_test = 4'b0001;
`endif
    check_regs("test_on");

    send({64'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0F00}, 64, 3, 1'b1);
    check_pulses("test_off", 1, 0);
    exp_disp[63:0] = 64'h0000_0000_0400_003C;
    exp_test = 4'b0000;
    check_regs("test_off");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/max7219_rx.md
# max7219_rx

Receive-side decoder for the MAX7219 serial LED protocol (DIN / LOAD-CS / CLK), modelling a daisy chain of `NDEV` 8x8 matrix devices. It oversamples the three serial lines in the system clock domain, assembles complete chain frames, and applies each device's register write to a shadow register file that is exposed as a flat display image plus control fields. It sits opposite the LED-matrix debug driver, either looped back on the board's expansion pins as a self-check or inside the system bench as the display model.

## Interface
Parameters:
- `NDEV`, 4: number of chained devices. Frame length is 16*NDEV bits.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `din`, `cs` and `sclk`. Minimum 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `din`  in  1  serial data, MSB first
- `cs`  in  1  LOAD; low while a frame is shifted, rising edge latches it
- `sclk`  in  1  serial clock; data is sampled on the rising edge
- `display`  out  NDEV*64  row data; device k, digit d (1..8) at `[64k+8(d-1)+7 : 64k+8(d-1)]`
- `intensity`  out  NDEV*4  register 0xA, low nibble, per device
- `scan_limit`  out  NDEV*3  register 0xB, low 3 bits
- `decode`  out  NDEV*8  register 0x9; stored only, never applied to `display`
- `shutdown_n`  out  NDEV  register 0xC bit 0
- `test`  out  NDEV  register 0xF bit 0
- `frame_valid`  out  1  one-cycle pulse when a frame is committed
- `frame_error`  out  1  one-cycle pulse on `cs` rise with a wrong bit count

## Operation
- Inputs pass through `SYNC_STAGES` flip-flops. Edges are detected on the synchronized values against a one-cycle-delayed copy.
- FSM states:
  - IDLE (`cs` high): on a `cs` fall, clear the bit counter and go to SHIFT.
  - SHIFT: on each `sclk` rise, shift `din` into bit 0 of a 16*NDEV shift register and increment the counter. The counter saturates at 16*NDEV+1. On a `cs` rise, go to COMMIT.
  - COMMIT (one cycle): then return to IDLE.
    - Count equals 16*NDEV: pulse `frame_valid`. Device k takes word `shreg[16k+15:16k]`, so device 0 gets the last word shifted and is the device nearest DIN.
    - Any other count: pulse `frame_error` and change no register.
- Word decode: address is `word[11:8]`; `word[15:12]` is ignored; data is `word[7:0]`.
  - 0x0: no-op.
  - 0x1..0x8: write digit row.
  - 0x9 / 0xA / 0xB / 0xC / 0xF: write the corresponding register (truncated to the port width).
  - 0xD, 0xE: ignored.
- Every device in one frame updates in the same cycle.
- Reset values: all outputs 0, including `shutdown_n`=0 (device shut down, as at power-up). Counter and shift register are cleared; FSM is IDLE.

## Timing
- Latency: a `cs` rising pin edge reaches the outputs and the pulse SYNC_STAGES+2 `clk` cycles later. That is SYNC_STAGES capture cycles, 1 edge-detect cycle, and 1 COMMIT register cycle.
- `sclk` high and low phases must each last at least 2 `clk` cycles. `din` must be stable for at least 1 `clk` around the synchronized `sclk` rise. Faster input is out of contract.
- The `cs` rise and `sclk` rise are detected in the same cycle: `cs` wins, the `sclk` edge is ignored, and the count is checked as it stands.
- `sclk` edges while in IDLE are ignored and the counter is unchanged.
- A `cs` low pulse with zero clocks gives count 0, which is ≠16*NDEV, so `frame_error` pulses.
- Overlong frame: the counter saturates, so it never wraps into a valid count and `frame_error` pulses.
- `rst` mid-frame: the partial frame is discarded and all registers return to reset values. The first frame after reset release must begin with a fresh `cs` fall.

## Configuration
- `MAX7219_RX_TEST_EN` defined:
  - A device with `test`=1 drives its 64 `display` bits to all ones, overriding its digit rows.
  - Its stored rows are preserved and reappear when `test` returns to 0.
- Not defined:
  - Register 0xF writes are ignored and `test` is tied to 0.
  - `display` always reflects the stored rows.

## Test plan
- NDEV=4: shift words 0x0155, 0x02AA, 0x0C01, 0x0A07 in that order, then raise `cs`.
  - `frame_valid` pulses once.
  - Device 3: digit1 = 0x55.
  - Device 2: digit2 = 0xAA.
  - Device 1: `shutdown_n`=1.
  - Device 0: `intensity`=7.
  - Everything else stays at 0.
- Short frame of 63 bits, then a long frame of 70 bits. Each gives one `frame_error` pulse, no `frame_valid`, and all outputs unchanged.
- Assert `rst` after 30 bits, release, then send a full valid frame. Only the second frame's values appear.
- `cs` rise coincident with the 64th `sclk` rise (the edge is dropped, count is 63): `frame_error`. The same frame with a 2-cycle gap before the `cs` rise: `frame_valid`.
- With `MAX7219_RX_TEST_EN` defined: write digit1=0x3C, then 0x0F01 to device 0. Device 0's `display` slice goes all ones. Writing 0x0F00 restores 0x3C in digit1. Without the macro, `test` stays 0 and `display` is unchanged.
- Latency check with SYNC_STAGES=2: the `frame_valid` rising edge occurs exactly 4 `clk` cycles after the `cs` pin rise.
